// File: rtl/seq_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_adder_pkg
//  Purpose  : Shared types and constants for the sequential chunk adder:
//             FSM state encoding, default geometry, chunk-count helper.
//  Revision : 1.0  initial release
// ============================================================================
package seq_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices making up a WIDTH-wide operand
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module   : chunk_adder
//  Purpose  : Combinational CHUNK-bit ripple adder built from full-adder
//             cells. Also exposes the carry into the MSB so the caller can
//             derive signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    // One full-adder cell per bit, carry rippling upward
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[CHUNK];
    assign cmsb = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module   : seq_chunk_adder
//  Purpose  : Multi-cycle unsigned adder. Latches a, b, cin, then adds CHUNK
//             bits per clock with the carry held in a register between
//             cycles. Valid/ready handshake on input and output.
//  Options  : SEQ_ADDER_OVF_EN - adds the ovf output (signed overflow).
//  Revision : 1.0  initial release
// ============================================================================
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int               CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] C_MASK = WIDTH'({CHUNK{1'b1}});

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;

    logic [31:0]       w_base;
    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK-1:0]  w_csum;
    logic              w_cout;
    logic              w_cmsb;
    logic [WIDTH-1:0]  w_sum_next;

    // Bit offset of the slice currently being processed
    assign w_base    = 32'(r_cnt) * 32'(CHUNK);
    assign w_a_chunk = CHUNK'(r_a >> w_base);
    assign w_b_chunk = CHUNK'(r_b >> w_base);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .cin  (r_carry),
        .sum  (w_csum),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    // Merge the fresh chunk result into its slot of the sum register
    assign w_sum_next = (sum & ~(C_MASK << w_base)) | (WIDTH'(w_csum) << w_base);

`ifndef SEQ_ADDER_OVF_EN
    // Carry into the MSB only feeds the optional overflow output
    wire w_unused_cmsb = w_cmsb;
`endif

    // Control FSM with registered handshake outputs and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef SEQ_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    sum     <= w_sum_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        cout      <= w_cout;
`ifdef SEQ_ADDER_OVF_EN
                        ovf       <= w_cmsb ^ w_cout;
`endif
                        r_cnt     <= '0;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    // No new accept in the handoff cycle; in_ready returns with IDLE
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_chunk_adder
//  Purpose  : Self-checking bench for seq_chunk_adder (16-bit, 4-bit chunks).
//             Expected results come from an arithmetic reference model and
//             are queued at issue time; a monitor pops them on each output
//             handshake and also checks accept-to-valid latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_chunk_adder;

    localparam int W   = 16;
    localparam int CH  = 4;
    localparam int NCH = W / CH;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SEQ_ADDER_OVF_EN
    logic         ovf;
`endif

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   rand_ready = 1'b0;
    int   edge_cnt = 0;
    int   acc_edge = 0;
    logic prev_ov = 1'b0;

    seq_chunk_adder #(
        .WIDTH (W),
        .CHUNK (CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SEQ_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer addition, signed range test for overflow
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        exp_t e;
        int   full;
        int   sres;
        full = int'(ta) + int'(tb) + int'(tc);
        sres = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
        e.s  = W'(full % (1 << W));
        e.co = (full >= (1 << W));
        e.ov = (sres > 32767) || (sres < -32768);
        return e;
    endfunction

    // Present one operand set, wait for the accept edge, queue expectation
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'(in_ready), 32'd1);
            return;
        end
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = 1'b1;
        q.push_back(model(ta, tb, tc));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom());
        b        = W'($urandom());
        cin      = 1'($urandom());
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((q.size() != 0 || !in_ready || out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Accept-edge bookkeeping for the latency check
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_edge <= edge_cnt;
        edge_cnt <= edge_cnt + 1;
    end

    // Random consumer backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: latency on each rising out_valid, scoreboard pop on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_ov)
                chk("latency", 32'(edge_cnt - 1 - acc_edge), 32'(NCH));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", 32'(sum), 32'(e.s));
                    chk("cout", 32'(cout), 32'(e.co));
`ifdef SEQ_ADDER_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.ov));
`endif
                end
            end
        end
        prev_ov = rst_n ? out_valid : 1'b0;
    end

    initial begin
        exp_t bp;
        int   guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        issue(16'h1234, 16'h1111, 1'b0);
        issue(16'hFFFF, 16'h0000, 1'b1);
        issue(16'h7FFF, 16'h0001, 1'b0);
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        issue(16'h8000, 16'h8000, 1'b0);
        wait_idle();

        // Backpressure: result must hold while consumer stalls
        out_ready = 1'b0;
        bp = model(16'hBEEF, 16'h4321, 1'b1);
        issue(16'hBEEF, 16'h4321, 1'b1);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            a        = W'($urandom());
            b        = W'($urandom());
            in_valid = ~in_valid;
            @(negedge clk);
            chk("bp_sum", 32'(sum), 32'(bp.s));
            chk("bp_cout", 32'(cout), 32'(bp.co));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        wait_idle();

        // Reset during the second BUSY cycle discards the partial result
        issue(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0003, 16'h0004, 1'b0);
        wait_idle();

        // Randomized traffic with random consumer backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++)
            issue(W'($urandom()), W'($urandom()), 1'($urandom()));
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
